// File: rtl/osc_ctrl_pkg.sv
// Shared types and helpers for the oscillator controller.
// Timer width covers the longer of the startup and window intervals.
package osc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    function automatic int timer_w(input int startup_cyc, input int win_cyc);
        int a;
        int b;
        a = $clog2(startup_cyc);
        b = $clog2(win_cyc);
        timer_w = (a > b) ? a : b;
        if (timer_w < 1) timer_w = 1;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for the oscillator output plus a registered
// rising-edge detector: one pulse per osc edge, three clk cycles late.
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_async};
            r_prev  <= r_sync[1];
            o_pulse <= r_sync[1] & ~r_prev;
        end
    end

endmodule

// File: rtl/osc_ctrl.sv
// Oscillator enable / startup / frequency-window controller.
// Define OSC_CTRL_MONITOR_EN to keep measuring windows while in RUN.
module osc_ctrl
    import osc_ctrl_pkg::*;
#(
    parameter int STARTUP_CYC = 1024,
    parameter int WIN_CYC     = 256,
    parameter int EDGE_MIN    = 40,
    parameter int EDGE_MAX    = 88,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_req,
    input  logic             osc_clk,
    output logic             osc_dis,
    output logic             osc_ready,
    output logic             osc_fault,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int             TW         = timer_w(STARTUP_CYC, WIN_CYC);
    localparam logic [TW-1:0]  START_LOAD = TW'(STARTUP_CYC - 1);
    localparam logic [TW-1:0]  WIN_LOAD   = TW'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_pulse;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_good;
    logic             w_win_end;

    osc_edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (osc_clk),
        .o_pulse (w_pulse)
    );

    // A pulse arriving at full scale marks the window as overflowed
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_pulse) begin
            if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
            else                  w_cnt_nxt = r_cnt + 1'b1;
        end
        w_good = !w_ovf_nxt
              && (int'(w_cnt_nxt) >= EDGE_MIN)
              && (int'(w_cnt_nxt) <= EDGE_MAX);
        w_win_end = (r_timer == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            osc_dis   <= 1'b1;
            osc_ready <= 1'b0;
            osc_fault <= 1'b0;
            edge_cnt  <= '0;
        end else if (!en_req) begin
            r_state   <= ST_OFF;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            osc_dis   <= 1'b1;
            osc_ready <= 1'b0;
            osc_fault <= 1'b0;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    r_state <= ST_START;
                    r_timer <= START_LOAD;
                    osc_dis <= 1'b0;
                end
                ST_START: begin
                    if (w_win_end) begin
                        r_state <= ST_MEASURE;
                        r_timer <= WIN_LOAD;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    r_cnt <= w_cnt_nxt;
                    r_ovf <= w_ovf_nxt;
                    if (w_win_end) begin
                        edge_cnt <= w_cnt_nxt;
                        if (w_good) begin
                            r_state   <= ST_RUN;
                            osc_ready <= 1'b1;
`ifdef OSC_CTRL_MONITOR_EN
                            r_timer   <= WIN_LOAD;
                            r_cnt     <= '0;
                            r_ovf     <= 1'b0;
`endif
                        end else begin
                            r_state   <= ST_FAULT;
                            osc_fault <= 1'b1;
                            osc_dis   <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef OSC_CTRL_MONITOR_EN
                    r_cnt <= w_cnt_nxt;
                    r_ovf <= w_ovf_nxt;
                    if (w_win_end) begin
                        edge_cnt <= w_cnt_nxt;
                        r_timer  <= WIN_LOAD;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                        if (!w_good) begin
                            r_state   <= ST_FAULT;
                            osc_ready <= 1'b0;
                            osc_fault <= 1'b1;
                            osc_dis   <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
`else
                    r_state <= ST_RUN;
`endif
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_ctrl.sv
// Randomized bench for osc_ctrl: osc_clk patterns checked against an
// edge-counting window model; a CNT_W=3 copy covers counter saturation.
module tb_osc_ctrl;

    localparam int S    = 16;
    localparam int W    = 32;
    localparam int EMIN = 6;
    localparam int EMAX = 10;
    localparam int HN   = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_req;
    logic       osc_clk;
    logic       osc_dis, osc_ready, osc_fault;
    logic [3:0] edge_cnt;
    logic       dis3, rdy3, flt3;
    logic [2:0] cnt3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int p2    = 0;
    int ph    = 0;
    bit hist [HN];

    osc_ctrl #(
        .STARTUP_CYC(S), .WIN_CYC(W), .EDGE_MIN(EMIN),
        .EDGE_MAX(EMAX), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .en_req(en_req), .osc_clk(osc_clk),
        .osc_dis(osc_dis), .osc_ready(osc_ready),
        .osc_fault(osc_fault), .edge_cnt(edge_cnt)
    );

    osc_ctrl #(
        .STARTUP_CYC(S), .WIN_CYC(W), .EDGE_MIN(EMIN),
        .EDGE_MAX(EMAX), .CNT_W(3)
    ) dut3 (
        .clk(clk), .rst(rst), .en_req(en_req), .osc_clk(osc_clk),
        .osc_dis(dis3), .osc_ready(rdy3),
        .osc_fault(flt3), .edge_cnt(cnt3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // p2 is the osc period in half clk cycles; 0 means stuck low
    function automatic bit gen(input int c);
        if (p2 == 0) return 1'b0;
        return ((2 * c + ph) % p2) < (p2 / 2);
    endfunction

    always @(negedge clk) begin
        osc_clk = gen(cyc);
        if (cyc < HN) hist[cyc] = osc_clk;
    end

    // Rises seen at sample k reach the counter at edge k+3
    function automatic int model_cnt(input int e);
        int n;
        n = 0;
        for (int k = e + S - 2; k <= e + S + W - 3; k++)
            if (hist[k] && !hist[k-1]) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_osc(input int per2);
        p2 = per2;
        ph = (per2 > 0) ? int'($urandom_range(0, per2 - 1)) : 0;
    endtask

    task automatic test_reset();
        int e;
        n_cmp++;
        if (osc_dis !== 1'b1 || osc_ready !== 1'b0 || osc_fault !== 1'b0
            || edge_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: dis=%b rdy=%b flt=%b cnt=%0d want 1 0 0 0",
                     osc_dis, osc_ready, osc_fault, edge_cnt);
        end
        rst = 1'b0;
        set_osc(8);
        tick(2);
        en_req = 1'b1;
        tick(S + W + 2);
        en_req = 1'b0;
        tick(1);
        n_cmp++;
        if (edge_cnt !== 4'd8 || osc_dis !== 1'b1 || osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL off_retains_cnt: cnt=%0d dis=%b rdy=%b want 8 1 0",
                     edge_cnt, osc_dis, osc_ready);
        end
        en_req = 1'b1;
        e = cyc;
        tick(S + 1 + $urandom_range(2, W - 4));
        rst = 1'b1;
        #1;
        n_cmp++;
        if (osc_dis !== 1'b1 || osc_ready !== 1'b0 || osc_fault !== 1'b0
            || edge_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_measure: dis=%b rdy=%b flt=%b cnt=%0d want 1 0 0 0",
                     osc_dis, osc_ready, osc_fault, edge_cnt);
        end
        en_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        if (e < 0) $display("unreachable");
    endtask

    task automatic test_window(input int per2, input string tag);
        int e, n, xc, x3;
        bit xf, xf3;
        en_req = 1'b0;
        set_osc(per2);
        tick(3);
        en_req = 1'b1;
        e = cyc;
        tick(1);
        n_cmp++;
        if (osc_dis !== 1'b0 || osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_dis_low: dis=%b rdy=%b want 0 0", tag, osc_dis, osc_ready);
        end
        tick(S + W - 1);
        n_cmp++;
        if (osc_ready !== 1'b0 || osc_fault !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early: rdy=%b flt=%b want 0 0", tag, osc_ready, osc_fault);
        end
        tick(1);
        n   = model_cnt(e);
        xc  = (n > 15) ? 15 : n;
        xf  = (n > 15) || (n < EMIN) || (n > EMAX);
        x3  = (n > 7) ? 7 : n;
        xf3 = (n > 7) || (n < EMIN) || (n > EMAX);
        n_cmp++;
        if (int'(edge_cnt) != xc || osc_fault !== xf || osc_ready !== !xf
            || osc_dis !== xf) begin
            n_err++;
            $display("FAIL %s_window: cnt=%0d flt=%b rdy=%b dis=%b want %0d %b %b %b",
                     tag, edge_cnt, osc_fault, osc_ready, osc_dis, xc, xf, !xf, xf);
        end
        n_cmp++;
        if (int'(cnt3) != x3 || flt3 !== xf3 || rdy3 !== !xf3) begin
            n_err++;
            $display("FAIL %s_sat3: cnt=%0d flt=%b rdy=%b want %0d %b %b",
                     tag, cnt3, flt3, rdy3, x3, xf3, !xf3);
        end
    endtask

    task automatic test_nominal();
        test_window(8, "per4");
        n_cmp++;
        if (edge_cnt !== 4'd8 || osc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL per4_exact: cnt=%0d rdy=%b want 8 1", edge_cnt, osc_ready);
        end
    endtask

    task automatic test_stuck();
        test_window(0, "stuck");
        n_cmp++;
        if (edge_cnt !== 4'd0 || osc_fault !== 1'b1 || osc_dis !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_fault: cnt=%0d flt=%b dis=%b want 0 1 1",
                     edge_cnt, osc_fault, osc_dis);
        end
        tick(5);
        n_cmp++;
        if (osc_fault !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_sticky: flt=%b want 1", osc_fault);
        end
        en_req = 1'b0;
        tick(1);
        n_cmp++;
        if (osc_fault !== 1'b0 || osc_dis !== 1'b1 || osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_clear: flt=%b dis=%b rdy=%b want 0 1 0",
                     osc_fault, osc_dis, osc_ready);
        end
    endtask

    task automatic test_fast();
        test_window(5, "per2p5");
        n_cmp++;
        if (osc_fault !== 1'b1 || edge_cnt < 4'd12) begin
            n_err++;
            $display("FAIL per2p5_fault: flt=%b cnt=%0d want 1 >=12", osc_fault, edge_cnt);
        end
        test_window(6, "per3");
        n_cmp++;
        if (cnt3 !== 3'd7 || flt3 !== 1'b1) begin
            n_err++;
            $display("FAIL per3_sat: cnt3=%0d flt3=%b want 7 1", cnt3, flt3);
        end
    endtask

    task automatic test_drop_restart();
        en_req = 1'b0;
        set_osc(8);
        tick(3);
        en_req = 1'b1;
        tick(11);
        en_req = 1'b0;
        tick(1);
        n_cmp++;
        if (osc_dis !== 1'b1 || osc_ready !== 1'b0 || osc_fault !== 1'b0) begin
            n_err++;
            $display("FAIL drop_off: dis=%b rdy=%b flt=%b want 1 0 0",
                     osc_dis, osc_ready, osc_fault);
        end
        en_req = 1'b1;
        tick(S + W);
        n_cmp++;
        if (osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL restart_early: rdy=%b want 0 at 48", osc_ready);
        end
        tick(1);
        n_cmp++;
        if (osc_ready !== 1'b1 || edge_cnt !== 4'd8) begin
            n_err++;
            $display("FAIL restart_ready: rdy=%b cnt=%0d want 1 8", osc_ready, edge_cnt);
        end
    endtask

    task automatic test_back_to_back();
        en_req = 1'b0;
        tick(1);
        n_cmp++;
        if (osc_dis !== 1'b1 || osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_off: dis=%b rdy=%b want 1 0", osc_dis, osc_ready);
        end
        en_req = 1'b1;
        tick(1);
        n_cmp++;
        if (osc_dis !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: dis=%b want 0", osc_dis);
        end
        tick(S + W - 1);
        n_cmp++;
        if (osc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_early: rdy=%b want 0", osc_ready);
        end
        tick(1);
        n_cmp++;
        if (osc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: rdy=%b want 1", osc_ready);
        end
    endtask

    task automatic test_run_hold();
        logic [3:0] c0;
        bit ok;
        c0 = edge_cnt;
        ok = 1'b0;
        p2 = 0;
`ifdef OSC_CTRL_MONITOR_EN
        for (int i = 0; i < 2 * W + 8 && !ok; i++) begin
            tick(1);
            if (osc_fault) ok = 1'b1;
        end
        n_cmp++;
        if (!ok || osc_ready !== 1'b0 || osc_dis !== 1'b1) begin
            n_err++;
            $display("FAIL monitor_fault: flt=%b rdy=%b dis=%b want 1 0 1",
                     osc_fault, osc_ready, osc_dis);
        end
`else
        ok = 1'b1;
        for (int i = 0; i < 2 * W + 8; i++) begin
            tick(1);
            if (osc_ready !== 1'b1 || osc_fault !== 1'b0 || edge_cnt !== c0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL run_static: rdy=%b flt=%b cnt=%0d want 1 0 %0d",
                     osc_ready, osc_fault, edge_cnt, c0);
        end
`endif
    endtask

    task automatic test_random();
        int pl [10] = '{0, 5, 6, 7, 8, 9, 10, 11, 12, 16};
        for (int i = 0; i < 8; i++)
            test_window(pl[$urandom_range(0, 9)], "rand");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        en_req  = 1'b0;
        osc_clk = 1'b0;
        tick(3);
        test_reset();
        test_nominal();
        test_stuck();
        test_fast();
        test_drop_restart();
        test_back_to_back();
        test_run_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
